ysyx_25030093_lsu: RTL and testbench

Multi-cycle load/store unit directly downstream of the ALU in the ysyx_25030093 core. It replaces the combinational paddr_read/paddr_write DPI calls: it takes the ALU-computed effective address, access size/sign and store data, and performs one access over a valid/ready memory bus. It returns the aligned, extended load result to writeback. While busy it holds off the core via req_ready.

---
 rtl/ysyx_25030093_lsu_if.sv | 26 ++
 rtl/ysyx_25030093_lsu.sv | 157 +++++++++++++++
 tb/tb_ysyx_25030093_lsu.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25030093_lsu_if.sv
// Memory-side valid/ready bus between the LSU (master) and the data memory (slave).
// Separate request and response handshakes allow arbitrarily long bus stalls.
interface ysyx_25030093_lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_W-1:0]     addr;
  logic                  wen;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rdata;

  modport master (
    output req_valid, addr, wen, wdata, wstrb, rsp_ready,
    input  req_ready, rsp_valid, rdata
  );

  modport slave (
    input  req_valid, addr, wen, wdata, wstrb, rsp_ready,
    output req_ready, rsp_valid, rdata
  );
endinterface

// File: rtl/ysyx_25030093_lsu.sv
// Multi-cycle load/store unit: one bus access per request, with alignment checks,
// store lane replication and load extraction/extension.
module ysyx_25030093_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  ysyx_25030093_lsu_if.master mem
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t state, state_n;

  logic              wen_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [1:0]        lane_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic              bus_wen_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic [3:0]        bus_wstrb_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic              misaligned;
  logic [DATA_W-1:0] store_data;
  logic [3:0]        store_strb;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] load_data;

  assign misaligned = (req_size == 2'd3)
                    | ((req_size == 2'd1) & req_addr[0])
                    | ((req_size == 2'd2) & (|req_addr[1:0]));

  // Stores replicate the datum across all lanes; the strobe selects the real bytes.
  always_comb begin
    store_data = '0;
    store_strb = 4'b0000;
    if (req_wen) begin
      case (req_size)
        2'd0: begin
          store_data = {4{req_wdata[7:0]}};
          store_strb = 4'b0001 << req_addr[1:0];
        end
        2'd1: begin
          store_data = {2{req_wdata[15:0]}};
          store_strb = 4'b0011 << req_addr[1:0];
        end
        default: begin
          store_data = req_wdata;
          store_strb = 4'b1111;
        end
      endcase
    end
  end

  assign shifted = mem.rdata >> {lane_q, 3'b000};

  always_comb begin
    load_data = shifted;
    case (size_q)
      2'd0:    load_data = signed_q ? {{24{shifted[7]}}, shifted[7:0]}
                                    : {24'd0, shifted[7:0]};
      2'd1:    load_data = signed_q ? {{16{shifted[15]}}, shifted[15:0]}
                                    : {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n       = state;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    mem.req_valid = 1'b0;
    mem.rsp_ready = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_n = misaligned ? DONE : REQ;
      end
      REQ: begin
        mem.req_valid = 1'b1;
        if (mem.req_ready) state_n = WAIT;
      end
      WAIT: begin
        mem.rsp_ready = 1'b1;
        if (mem.rsp_valid) state_n = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Bus fields are loaded at acceptance so they stay stable through any REQ stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q       <= 1'b0;
      size_q      <= 2'd0;
      signed_q    <= 1'b0;
      lane_q      <= 2'd0;
      bus_addr_q  <= '0;
      bus_wen_q   <= 1'b0;
      bus_wdata_q <= '0;
      bus_wstrb_q <= 4'b0000;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        wen_q    <= req_wen;
        size_q   <= req_size;
        signed_q <= req_signed;
        lane_q   <= req_addr[1:0];
        if (misaligned) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end else begin
          bus_addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
          bus_wen_q   <= req_wen;
          bus_wdata_q <= store_data;
          bus_wstrb_q <= store_strb;
        end
      end
      if (state == WAIT && mem.rsp_valid) begin
        rdata_q <= wen_q ? '0 : load_data;
        err_q   <= 1'b0;
      end
    end
  end

  assign mem.addr   = bus_addr_q;
  assign mem.wen    = bus_wen_q;
  assign mem.wdata  = bus_wdata_q;
  assign mem.wstrb  = bus_wstrb_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_ysyx_25030093_lsu.sv
// Directed bench for ysyx_25030093_lsu: aligned/unaligned loads and stores,
// misaligned errors, bus stalls and reset during an outstanding access.
module tb_ysyx_25030093_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks = 0;
  int errors = 0;

  int          obsLatency;
  logic        obsReqSeen;
  logic [31:0] obsAddr;
  logic        obsWen;
  logic [31:0] obsWdata;
  logic [3:0]  obsWstrb;
  logic [31:0] obsRdata;
  logic        obsErr;

  always #5 clk = ~clk;

  ysyx_25030093_lsu_if mem_if ();

  ysyx_25030093_lsu dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem        (mem_if.master)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Presents one request for a single cycle; returns one time unit after the accepting edge.
  task automatic issueReq(input logic wen, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge clk); #1;
    req_valid  = 1'b1;
    req_wen    = wen;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk); #1;
    req_valid  = 1'b0;
  endtask

  // Issues a request and observes the bus and response, bounded to 50 cycles.
  task automatic applyStimulus(input logic wen, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata);
    logic found;
    issueReq(wen, size, sgn, addr, wdata);
    found      = 1'b0;
    obsReqSeen = 1'b0;
    obsLatency = -1;
    for (int n = 1; n <= 50 && !found; n++) begin
      @(negedge clk);
      if (mem_if.req_valid) begin
        obsReqSeen = 1'b1;
        obsAddr    = mem_if.addr;
        obsWen     = mem_if.wen;
        obsWdata   = mem_if.wdata;
        obsWstrb   = mem_if.wstrb;
      end
      if (resp_valid) begin
        found      = 1'b1;
        obsLatency = n;
        obsRdata   = resp_rdata;
        obsErr     = resp_err;
      end
    end
  endtask

  initial begin
    rst              = 1'b1;
    req_valid        = 1'b0;
    req_wen          = 1'b0;
    req_size         = 2'd0;
    req_signed       = 1'b0;
    req_addr         = '0;
    req_wdata        = '0;
    mem_if.req_ready = 1'b0;
    mem_if.rsp_valid = 1'b0;
    mem_if.rdata     = '0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_req_ready",  32'(req_ready),        32'd1);
    checkOutput("rst_resp_valid", 32'(resp_valid),       32'd0);
    checkOutput("rst_resp_rdata", resp_rdata,            32'd0);
    checkOutput("rst_resp_err",   32'(resp_err),         32'd0);
    checkOutput("rst_mem_valid",  32'(mem_if.req_valid), 32'd0);
    checkOutput("rst_rsp_ready",  32'(mem_if.rsp_ready), 32'd0);
    checkOutput("rst_mem_addr",   mem_if.addr,           32'd0);
    checkOutput("rst_mem_wstrb",  32'(mem_if.wstrb),     32'd0);

    mem_if.req_ready = 1'b1;
    mem_if.rsp_valid = 1'b1;

    mem_if.rdata = 32'hDEADBEEF;
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h8000_0004, 32'd0);
    checkOutput("lw_latency", 32'(obsLatency), 32'd3);
    checkOutput("lw_req_seen", 32'(obsReqSeen), 32'd1);
    checkOutput("lw_mem_addr", obsAddr, 32'h8000_0004);
    checkOutput("lw_mem_wen", 32'(obsWen), 32'd0);
    checkOutput("lw_wstrb", 32'(obsWstrb), 32'd0);
    checkOutput("lw_rdata", obsRdata, 32'hDEADBEEF);
    checkOutput("lw_err", 32'(obsErr), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("lw_rdata_hold", resp_rdata, 32'hDEADBEEF);
    checkOutput("idle_resp_valid", 32'(resp_valid), 32'd0);

    mem_if.rdata = 32'h80FF1234;
    applyStimulus(1'b0, 2'd0, 1'b1, 32'h8000_0003, 32'd0);
    checkOutput("lb_rdata", obsRdata, 32'hFFFFFF80);
    checkOutput("lb_mem_addr", obsAddr, 32'h8000_0000);
    applyStimulus(1'b0, 2'd0, 1'b0, 32'h8000_0003, 32'd0);
    checkOutput("lbu_rdata", obsRdata, 32'h0000_0080);

    mem_if.rdata = 32'h9ABC0000;
    applyStimulus(1'b0, 2'd1, 1'b1, 32'h8000_0002, 32'd0);
    checkOutput("lh_rdata", obsRdata, 32'hFFFF9ABC);
    applyStimulus(1'b0, 2'd1, 1'b0, 32'h8000_0002, 32'd0);
    checkOutput("lhu_rdata", obsRdata, 32'h0000_9ABC);

    mem_if.rdata = 32'h5555_5555;
    applyStimulus(1'b1, 2'd0, 1'b0, 32'h8000_0001, 32'h0000_00A5);
    checkOutput("sb_mem_addr", obsAddr, 32'h8000_0000);
    checkOutput("sb_mem_wen", 32'(obsWen), 32'd1);
    checkOutput("sb_wdata", obsWdata, 32'hA5A5A5A5);
    checkOutput("sb_wstrb", 32'(obsWstrb), 32'h2);
    checkOutput("sb_rdata", obsRdata, 32'd0);
    checkOutput("sb_latency", 32'(obsLatency), 32'd3);

    applyStimulus(1'b1, 2'd1, 1'b0, 32'h8000_0002, 32'h0000_1234);
    checkOutput("sh_wdata", obsWdata, 32'h12341234);
    checkOutput("sh_wstrb", 32'(obsWstrb), 32'hC);

    applyStimulus(1'b1, 2'd2, 1'b0, 32'h8000_0010, 32'hCAFEF00D);
    checkOutput("sw_mem_addr", obsAddr, 32'h8000_0010);
    checkOutput("sw_wdata", obsWdata, 32'hCAFEF00D);
    checkOutput("sw_wstrb", 32'(obsWstrb), 32'hF);

    applyStimulus(1'b0, 2'd2, 1'b0, 32'h8000_0002, 32'd0);
    checkOutput("mis_lw_req_seen", 32'(obsReqSeen), 32'd0);
    checkOutput("mis_lw_latency", 32'(obsLatency), 32'd1);
    checkOutput("mis_lw_err", 32'(obsErr), 32'd1);
    checkOutput("mis_lw_rdata", obsRdata, 32'd0);

    mem_if.rdata = 32'hDEADBEEF;
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h8000_0004, 32'd0);
    checkOutput("lw_after_err_err", 32'(obsErr), 32'd0);
    checkOutput("lw_after_err_rdata", obsRdata, 32'hDEADBEEF);

    applyStimulus(1'b1, 2'd1, 1'b0, 32'h8000_0001, 32'h0000_1234);
    checkOutput("mis_sh_req_seen", 32'(obsReqSeen), 32'd0);
    checkOutput("mis_sh_latency", 32'(obsLatency), 32'd1);
    checkOutput("mis_sh_err", 32'(obsErr), 32'd1);
    checkOutput("mis_sh_rdata", obsRdata, 32'd0);

    applyStimulus(1'b0, 2'd3, 1'b0, 32'h8000_0000, 32'd0);
    checkOutput("size3_req_seen", 32'(obsReqSeen), 32'd0);
    checkOutput("size3_err", 32'(obsErr), 32'd1);

    // Request held off for five cycles, then response delayed three cycles.
    mem_if.req_ready = 1'b0;
    mem_if.rsp_valid = 1'b0;
    mem_if.rdata     = 32'h11223344;
    issueReq(1'b0, 2'd2, 1'b0, 32'h8000_0008, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_req_valid", 32'(mem_if.req_valid), 32'd1);
      checkOutput("stall_mem_addr", mem_if.addr, 32'h8000_0008);
      checkOutput("stall_wstrb", 32'(mem_if.wstrb), 32'd0);
    end
    mem_if.req_ready = 1'b1;
    @(posedge clk); #1;
    mem_if.req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("wait_rsp_ready", 32'(mem_if.rsp_ready), 32'd1);
      checkOutput("wait_req_valid", 32'(mem_if.req_valid), 32'd0);
      checkOutput("wait_resp_valid", 32'(resp_valid), 32'd0);
    end
    mem_if.rsp_valid = 1'b1;
    @(negedge clk);
    checkOutput("stall_resp_valid", 32'(resp_valid), 32'd1);
    checkOutput("stall_rdata", resp_rdata, 32'h11223344);
    mem_if.rsp_valid = 1'b0;

    // Reset while a second load is waiting for its response.
    mem_if.req_ready = 1'b1;
    issueReq(1'b0, 2'd2, 1'b0, 32'h8000_000C, 32'd0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("wait2_rsp_ready", 32'(mem_if.rsp_ready), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_req_ready", 32'(req_ready), 32'd1);
    checkOutput("abort_req_valid", 32'(mem_if.req_valid), 32'd0);
    checkOutput("abort_rsp_ready", 32'(mem_if.rsp_ready), 32'd0);
    checkOutput("abort_mem_addr", mem_if.addr, 32'd0);
    checkOutput("abort_mem_wen", 32'(mem_if.wen), 32'd0);
    checkOutput("abort_mem_wdata", mem_if.wdata, 32'd0);
    checkOutput("abort_mem_wstrb", 32'(mem_if.wstrb), 32'd0);
    checkOutput("abort_resp_rdata", resp_rdata, 32'd0);
    checkOutput("abort_resp_err", 32'(resp_err), 32'd0);
    mem_if.rsp_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("abort_no_resp", 32'(resp_valid), 32'd0);
      checkOutput("abort_idle", 32'(req_ready), 32'd1);
    end
    mem_if.rsp_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
